// File: rtl/usb_arb_pkg.sv
// Shared types and helpers for the USB endpoint arbiter.
package usb_arb_pkg;

  localparam int NUM_EP_DEFAULT = 4;
  // Widest endpoint count the arbiter supports; onehot() is sized to this and
  // callers truncate to their own NUM_EP.
  localparam int MAX_EP = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } in_state_t;

  function automatic logic [MAX_EP-1:0] onehot(input logic [2:0] idx);
    logic [MAX_EP-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/usb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module usb_rr_pick
  import usb_arb_pkg::*;
#(
  parameter  int NUM_EP = NUM_EP_DEFAULT,
  localparam int PW     = $clog2(NUM_EP)
) (
  input  logic [NUM_EP-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [NUM_EP-1:0] gnt,
  output logic              any,
  output logic [PW-1:0]     idx
);

  // Scan from the farthest offset down so the request closest to ptr wins last.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int off = NUM_EP - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % NUM_EP]) begin
        any = 1'b1;
        idx = PW'((int'(ptr) + off) % NUM_EP);
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/usb_ep_arbiter.sv
// Shares the core's OUT read port and IN write port among NUM_EP endpoints.
// IN side holds a per-packet lock so one packet carries bytes of one endpoint.
//
//   state  | meaning
//   IDLE   | no IN packet in progress; grant round-robin from in_ptr
//   LOCKED | packet owned by 'owner'; only owner may be granted
module usb_ep_arbiter
  import usb_arb_pkg::*;
#(
  parameter int NUM_EP       = NUM_EP_DEFAULT,
  parameter int LOCK_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                us_tick,
  input  logic [NUM_EP-1:0]   out_ep_req,
  output logic [NUM_EP-1:0]   out_ep_grant,
  output logic                out_data_get,
  input  logic [NUM_EP-1:0]   in_ep_req,
  output logic [NUM_EP-1:0]   in_ep_grant,
  input  logic [8*NUM_EP-1:0] in_ep_data,
  input  logic [NUM_EP-1:0]   in_ep_data_done,
  output logic                in_data_put,
  output logic [7:0]          in_data,
  output logic                in_data_done,
  input  logic                in_pkt_end
);

  localparam int PW = $clog2(NUM_EP);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [PW-1:0] LAST_EP = PW'(NUM_EP - 1);

  in_state_t   state, state_nxt;
  logic [PW-1:0] out_ptr, out_ptr_nxt;
  logic [PW-1:0] in_ptr, in_ptr_nxt;
  logic [PW-1:0] owner, owner_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [NUM_EP-1:0] out_pick_gnt, in_pick_gnt;
  logic              out_pick_any, in_pick_any;
  logic [PW-1:0]     out_pick_idx, in_pick_idx;

  logic [NUM_EP-1:0] owner_oh;
  logic [7:0]        owner_byte, pick_byte;
  logic [NUM_EP-1:0] in_grant_raw;
  logic [7:0]        in_byte;
  logic              in_done_raw;

  usb_rr_pick #(.NUM_EP(NUM_EP)) u_out_pick (
    .req (out_ep_req),
    .ptr (out_ptr),
    .gnt (out_pick_gnt),
    .any (out_pick_any),
    .idx (out_pick_idx)
  );

  usb_rr_pick #(.NUM_EP(NUM_EP)) u_in_pick (
    .req (in_ep_req),
    .ptr (in_ptr),
    .gnt (in_pick_gnt),
    .any (in_pick_any),
    .idx (in_pick_idx)
  );

  assign owner_oh   = NUM_EP'(onehot(3'(owner)));
  assign owner_byte = in_ep_data[int'(owner)*8 +: 8];
  assign pick_byte  = in_ep_data[int'(in_pick_idx)*8 +: 8];

  // Next-state for pointers, IN lock FSM, idle-timeout counter and IN mux.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    cnt_nxt      = cnt;
    in_ptr_nxt   = in_ptr;
    out_ptr_nxt  = out_ptr;
    in_grant_raw = '0;
    in_byte      = '0;
    in_done_raw  = 1'b0;

    if (out_pick_any)
      out_ptr_nxt = (out_pick_idx == LAST_EP) ? '0 : out_pick_idx + PW'(1);

    case (state)
      IDLE: begin
        in_grant_raw = in_pick_gnt;
        if (in_pick_any) begin
          in_byte     = pick_byte;
          in_done_raw = in_ep_data_done[in_pick_idx];
          state_nxt   = LOCKED;
          owner_nxt   = in_pick_idx;
          in_ptr_nxt  = (in_pick_idx == LAST_EP) ? '0 : in_pick_idx + PW'(1);
          cnt_nxt     = '0;
        end
      end
      LOCKED: begin
        in_grant_raw = in_ep_req & owner_oh;
        in_byte      = owner_byte;
        in_done_raw  = in_ep_data_done[owner];
        // Release beats the timeout; a coincident owner byte still goes out.
        if (in_ep_data_done[owner] || in_pkt_end) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (in_ep_req[owner]) begin
          cnt_nxt = '0;
        end else if (us_tick) begin
          if (cnt >= CW'(LOCK_TIMEOUT - 1)) begin
            state_nxt = IDLE;
            cnt_nxt   = CW'(LOCK_TIMEOUT);
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      owner   <= '0;
      cnt     <= '0;
      in_ptr  <= '0;
      out_ptr <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      cnt     <= cnt_nxt;
      in_ptr  <= in_ptr_nxt;
      out_ptr <= out_ptr_nxt;
    end
  end

  // Outputs are forced quiet during reset so grants drop in the same cycle.
  assign out_ep_grant = rstn ? out_pick_gnt : '0;
  assign out_data_get = |out_ep_grant;
  assign in_ep_grant  = rstn ? in_grant_raw : '0;
  assign in_data_put  = |in_ep_grant;
  assign in_data      = rstn ? in_byte : 8'h00;
  assign in_data_done = rstn & in_done_raw;

endmodule

// File: tb/tb_usb_ep_arbiter.sv
// Scoreboard bench for usb_ep_arbiter: the driver predicts each cycle's outputs
// from a behavioural model and queues them; the monitor pops and compares.
module tb_usb_ep_arbiter;

  localparam int N  = 4;
  localparam int LT = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          us_tick;
  logic [N-1:0]  out_ep_req, out_ep_grant;
  logic          out_data_get;
  logic [N-1:0]  in_ep_req, in_ep_grant;
  logic [8*N-1:0] in_ep_data;
  logic [N-1:0]  in_ep_data_done;
  logic          in_data_put;
  logic [7:0]    in_data;
  logic          in_data_done;
  logic          in_pkt_end;

  always #5 clk = ~clk;

  usb_ep_arbiter #(.NUM_EP(N), .LOCK_TIMEOUT(LT)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .us_tick         (us_tick),
    .out_ep_req      (out_ep_req),
    .out_ep_grant    (out_ep_grant),
    .out_data_get    (out_data_get),
    .in_ep_req       (in_ep_req),
    .in_ep_grant     (in_ep_grant),
    .in_ep_data      (in_ep_data),
    .in_ep_data_done (in_ep_data_done),
    .in_data_put     (in_data_put),
    .in_data         (in_data),
    .in_data_done    (in_data_done),
    .in_pkt_end      (in_pkt_end)
  );

  typedef struct {
    logic [N-1:0] og;
    logic         odg;
    logic [N-1:0] ig;
    logic         idp;
    logic [7:0]   id;
    logic         idd;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: plain integers, not the RTL encoding.
  int   m_optr, m_iptr, m_owner, m_idle_ticks;
  bit   m_locked;
  logic [7:0] bytes_v[N];

  function automatic int rr_first(input logic [N-1:0] r, input int start);
    for (int o = 0; o < N; o++)
      if (r[(start + o) % N]) return (start + o) % N;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rs, input logic [N-1:0] oreq, input logic [N-1:0] ireq,
                      input logic [N-1:0] idone, input logic pe, input logic tk);
    exp_t e;
    int   k;
    @(posedge clk);
    #1;
    rstn            = rs;
    out_ep_req      = oreq;
    in_ep_req       = ireq;
    in_ep_data_done = idone;
    in_pkt_end      = pe;
    us_tick         = tk;
    for (int i = 0; i < N; i++) in_ep_data[i*8 +: 8] = bytes_v[i];
    e.og = '0; e.odg = 1'b0; e.ig = '0; e.idp = 1'b0; e.id = 8'h00; e.idd = 1'b0;
    if (!rs) begin
      m_optr = 0; m_iptr = 0; m_owner = 0; m_idle_ticks = 0; m_locked = 0;
    end else begin
      k = rr_first(oreq, m_optr);
      if (k >= 0) begin
        e.og   = N'(1 << k);
        e.odg  = 1'b1;
        m_optr = (k + 1) % N;
      end
      if (!m_locked) begin
        k = rr_first(ireq, m_iptr);
        if (k >= 0) begin
          e.ig   = N'(1 << k);
          e.idp  = 1'b1;
          e.id   = bytes_v[k];
          e.idd  = idone[k];
          m_locked = 1; m_owner = k; m_iptr = (k + 1) % N; m_idle_ticks = 0;
        end
      end else begin
        e.id  = bytes_v[m_owner];
        e.idd = idone[m_owner];
        if (ireq[m_owner]) begin
          e.ig  = N'(1 << m_owner);
          e.idp = 1'b1;
        end
        if (idone[m_owner] || pe) begin
          m_locked = 0; m_idle_ticks = 0;
        end else if (ireq[m_owner]) begin
          m_idle_ticks = 0;
        end else if (tk) begin
          m_idle_ticks++;
          if (m_idle_ticks >= LT) m_locked = 0;
        end
      end
    end
    q.push_back(e);
  endtask

  // Monitor: compare every presented cycle against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_ep_grant", 32'(out_ep_grant), 32'(e.og));
        chk("out_data_get", 32'(out_data_get), 32'(e.odg));
        chk("in_ep_grant",  32'(in_ep_grant),  32'(e.ig));
        chk("in_data_put",  32'(in_data_put),  32'(e.idp));
        chk("in_data",      32'(in_data),      32'(e.id));
        chk("in_data_done", 32'(in_data_done), 32'(e.idd));
        chk("out_onehot0",  32'($onehot0(out_ep_grant)), 32'd1);
        chk("in_onehot0",   32'($onehot0(in_ep_grant)),  32'd1);
        chk("out_subset",   32'((out_ep_grant & ~out_ep_req) == '0), 32'd1);
        chk("in_subset",    32'((in_ep_grant & ~in_ep_req) == '0),   32'd1);
      end
    end
  end

  initial begin
    rstn = 1'b0; us_tick = 1'b0; out_ep_req = '0; in_ep_req = '0;
    in_ep_data = '0; in_ep_data_done = '0; in_pkt_end = 1'b0;
    for (int i = 0; i < N; i++) bytes_v[i] = 8'($urandom);
    m_optr = 0; m_iptr = 0; m_owner = 0; m_idle_ticks = 0; m_locked = 0;

    step(0, 4'hF, 4'hF, 4'h0, 0, 0);
    step(0, 4'h0, 4'h0, 4'h0, 0, 0);

    // OUT round-robin with all requesting
    repeat (8) step(1, 4'hF, 4'h0, 4'h0, 0, 0);

    // IN lock, non-owner blocked, done release, regrant
    step(1, 4'h0, 4'b0110, 4'h0, 0, 0);
    step(1, 4'h0, 4'b0100, 4'h0, 0, 0);
    step(1, 4'h0, 4'b0100, 4'b0010, 0, 0);
    step(1, 4'h0, 4'b0100, 4'h0, 0, 0);

    // Owner 2 idle timeout with a ticker every 3 cycles
    for (int i = 0; i < 24; i++) step(1, 4'h0, 4'b1000, 4'h0, 0, (i % 3) == 2);
    step(1, 4'h0, 4'b1000, 4'h0, 0, 0);
    step(1, 4'h0, 4'h0, 4'h0, 1, 0);

    // Owner request after 5th tick clears the counter
    step(1, 4'h0, 4'b0100, 4'h0, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 4'h0, 4'b1000, 4'h0, 0, (i % 3) == 2);
    step(1, 4'h0, 4'b0100, 4'h0, 0, 0);
    for (int i = 0; i < 21; i++) step(1, 4'h0, 4'b1000, 4'h0, 0, (i % 3) == 2);
    step(1, 4'h0, 4'b1000, 4'h0, 0, 1);
    step(1, 4'h0, 4'h0, 4'h0, 1, 0);

    // Data mux and pkt_end coincident with owner grant
    bytes_v[0] = 8'hA0; bytes_v[1] = 8'hB1; bytes_v[2] = 8'hC2; bytes_v[3] = 8'hD3;
    step(1, 4'h0, 4'b1000, 4'h0, 0, 0);
    step(1, 4'h0, 4'b1000, 4'h0, 1, 0);
    step(1, 4'h0, 4'b0001, 4'h0, 0, 0);

    // Reset mid-packet
    step(1, 4'hF, 4'hF, 4'h0, 0, 0);
    step(0, 4'hF, 4'hF, 4'h0, 0, 0);
    step(1, 4'hF, 4'hF, 4'h0, 0, 0);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) bytes_v[i] = 8'($urandom);
      step($urandom_range(0, 63) != 0,
           N'($urandom),
           ($urandom_range(0, 3) == 0) ? N'(0) : N'($urandom),
           ($urandom_range(0, 7) == 0) ? N'($urandom) : N'(0),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 2) == 0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
